// File: rtl/irq_encoder4.sv
// irq_encoder4: 4-source active-low interrupt request encoder.
// Synchronizes nREQ, latches pending requests (edge or level mode), and drives a
// registered active-low nINT plus the {selB,selA} vector of the highest-priority
// enabled source. nIACK from the CPU clears the served pending bit.
// Optional feature: define IRQ_MASK_EN to add the mask_we/mask_d mask register.
module irq_encoder4 #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          EDGE        = 1'b1
) (
  input  logic       clk,
  input  logic       nRST,
  input  logic [3:0] nREQ,
  input  logic       nIACK,
`ifdef IRQ_MASK_EN
  input  logic       mask_we,
  input  logic [3:0] mask_d,
`endif
  output logic       nINT,
  output logic       selA,
  output logic       selB
);

  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned VEC_W   = 2;
  localparam int unsigned SH_W    = SYNC_STAGES * NUM_SRC;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ASSERT = 2'b01,
    ACK    = 2'b10
  } stateT;

  logic [SH_W-1:0]    syncSh;
  logic [NUM_SRC-1:0] syncd;
  logic [NUM_SRC-1:0] prevSync;
  logic [NUM_SRC-1:0] fallSet;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] pendingNext;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] eff;
  logic               effAny;
  logic [VEC_W-1:0]   effVec;
  logic [NUM_SRC-1:0] ackClr;
  logic [NUM_SRC-1:0] clrOneHot;
  logic [VEC_W-1:0]   vecQ;
  logic [VEC_W-1:0]   vecNext;
  logic               nIntNext;
  stateT              state;
  stateT              stateNext;

  // Synchronizer shift chain; the oldest slice is the synced request level
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      syncSh   <= '1;
      prevSync <= '1;
    end else begin
      syncSh   <= {syncSh[SH_W-NUM_SRC-1:0], nREQ};
      prevSync <= syncd;
    end
  end

  assign syncd   = syncSh[SH_W-1 -: NUM_SRC];
  assign fallSet = prevSync & ~syncd;

`ifdef IRQ_MASK_EN
  // Source enable mask, written by the CPU
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      mask <= '1;
    end else if (mask_we) begin
      mask <= mask_d;
    end
  end
`else
  assign mask = '1;
`endif

  assign eff    = pending & mask;
  assign effAny = |eff;

  // Lowest set bit of eff wins; 2'b11 doubles as the value when nothing is set
  always_comb begin
    effVec = 2'b11;
    if (eff[0]) begin
      effVec = 2'b00;
    end else if (eff[1]) begin
      effVec = 2'b01;
    end else if (eff[2]) begin
      effVec = 2'b10;
    end
  end

  assign clrOneHot = NUM_SRC'(1) << vecQ;

  // Pending update: a new falling edge beats a same-cycle ack clear
  always_comb begin
    pendingNext = pending;
    if (EDGE) begin
      pendingNext = (pending & ~ackClr) | fallSet;
    end else begin
      pendingNext = ~syncd;
    end
  end

  // Pending register
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      pending <= '0;
    end else begin
      pending <= pendingNext;
    end
  end

  // Next-state, next-output and ack-clear logic
  always_comb begin
    stateNext = state;
    vecNext   = vecQ;
    ackClr    = '0;
    case (state)
      IDLE: begin
        // An ack with nothing asserted is spurious and reports the default vector
        if (!nIACK) begin
          stateNext = ACK;
          vecNext   = 2'b11;
        end else if (effAny) begin
          stateNext = ASSERT;
          vecNext   = effVec;
        end
      end
      ASSERT: begin
        if (!nIACK) begin
          // Freeze the vector the CPU read and clear only that source
          stateNext = ACK;
          if (EDGE) begin
            ackClr = clrOneHot;
          end
        end else if (!effAny) begin
          stateNext = IDLE;
        end else begin
          vecNext = effVec;
        end
      end
      ACK: begin
        if (nIACK) begin
          if (effAny) begin
            stateNext = ASSERT;
            vecNext   = effVec;
          end else begin
            stateNext = IDLE;
          end
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
    nIntNext = (stateNext != ASSERT);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      nINT  <= 1'b1;
      vecQ  <= '0;
    end else begin
      state <= stateNext;
      nINT  <= nIntNext;
      vecQ  <= vecNext;
    end
  end

  assign selA = vecQ[0];
  assign selB = vecQ[1];

endmodule
